// File: rtl/multi_frequency_divider.sv
// multi_frequency_divider: per-channel programmable clock dividers with glitch-free reload and Sync realign; defining FD_DUTY_EN adds the ConfigDuty port and a pending high-time per channel
module multi_frequency_divider #(
  parameter int WIDTH = 32,
  parameter int CHANNELS = 4,
  parameter int CSEL_W = 2
) (
  input logic Clk,
  input logic Reset,
  input logic [WIDTH-1:0] Din,
  input logic ConfigDiv,
  input logic [CSEL_W-1:0] ChanSel,
  input logic [CHANNELS-1:0] Enable,
  input logic Sync,
`ifdef FD_DUTY_EN
  input logic ConfigDuty,
`endif
  output logic [CHANNELS-1:0] ClkOut,
  output logic [CHANNELS-1:0] Tick,
  output logic [CHANNELS-1:0] Pending
);
  logic sel_ok;
  assign sel_ok = 32'(ChanSel) < 32'(CHANNELS);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] div, h, pdiv, cnt, nh;
    logic hit, wr_div, wr_duty, last, load, ck, tk, pend;
    assign hit = sel_ok && ChanSel == CSEL_W'(i);
    assign wr_div = hit && ConfigDiv && Din != '0;
    assign last = cnt == div - WIDTH'(1);
    assign load = pend && (Sync || !Enable[i] || last);
`ifdef FD_DUTY_EN
    logic [WIDTH-1:0] ph;
    assign wr_duty = hit && ConfigDuty;
    assign nh = ph;
    always_ff @(posedge Clk) ph <= Reset ? WIDTH'(1) : wr_duty ? Din : ph;
`else
    assign wr_duty = 1'b0;
    assign nh = pdiv == WIDTH'(1) ? WIDTH'(1) : pdiv >> 1;
`endif
    always_ff @(posedge Clk) begin
      if (Reset) begin
        div <= WIDTH'(1);
        h <= WIDTH'(1);
        pdiv <= WIDTH'(1);
        cnt <= '0;
        pend <= 1'b0;
        ck <= 1'b0;
        tk <= 1'b0;
      end else begin
        ck <= !Sync && Enable[i] && cnt < h;
        tk <= !Sync && Enable[i] && cnt == '0;
        cnt <= (Sync || !Enable[i] || last) ? '0 : cnt + WIDTH'(1);
        div <= load ? pdiv : div;
        h <= load ? nh : h;
        pend <= wr_div || wr_duty || (pend && !load);
        pdiv <= wr_div ? Din : pdiv;
      end
    end
    assign ClkOut[i] = ck;
    assign Tick[i] = tk;
    assign Pending[i] = pend;
  end
endmodule
